// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the fetch-stage controller.
// Default widths, reset PC and controller state encodings.
package if_fetch_ctrl_pkg;

    localparam int IFC_PC_WIDTH   = 10;
    localparam int IFC_INST_WIDTH = 32;
    localparam int IFC_RESET_PC   = 0;

    typedef enum logic [1:0] {
        IFC_BOOT = 2'd0,
        IFC_RUN  = 2'd1,
        IFC_HOLD = 2'd2
    } ifc_state_e;

endpackage

// File: rtl/if_fetch_ctrl_hold_buf.sv
// Stall holding register for the fetch stage.
// Captures pc+inst on load; sel picks held or live path.
module if_hold_buf
    import if_fetch_ctrl_pkg::*;
#(
    parameter int PC_WIDTH   = IFC_PC_WIDTH,
    parameter int INST_WIDTH = IFC_INST_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  sel,
    input  logic [PC_WIDTH-1:0]   live_pc,
    input  logic [INST_WIDTH-1:0] live_inst,
    output logic [PC_WIDTH-1:0]   pc,
    output logic [INST_WIDTH-1:0] inst
);

    logic [PC_WIDTH-1:0]   hold_pc;
    logic [INST_WIDTH-1:0] hold_inst;

    // Capture the presented instruction when the stage starts holding.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_pc   <= '0;
            hold_inst <= '0;
        end else if (load) begin
            hold_pc   <= live_pc;
            hold_inst <= live_inst;
        end
    end

    assign pc   = sel ? hold_pc   : live_pc;
    assign inst = sel ? hold_inst : live_inst;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller: PC generation, BRAM request issue,
// stall holding and redirect, aligned across 1-cycle read latency.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int PC_WIDTH   = IFC_PC_WIDTH,
    parameter int INST_WIDTH = IFC_INST_WIDTH,
    parameter int RESET_PC   = IFC_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [PC_WIDTH-1:0]   redirect_pc_i,
    output logic                  imem_en_o,
    output logic [PC_WIDTH-1:0]   imem_addr_o,
    input  logic [INST_WIDTH-1:0] imem_rdata_i,
    output logic                  if_valid_o,
    output logic [PC_WIDTH-1:0]   if_pc_o,
    output logic [INST_WIDTH-1:0] if_inst_o
);

    localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    ifc_state_e            state_q, state_d;
    logic [PC_WIDTH-1:0]   fetch_q, fetch_d;
    logic [PC_WIDTH-1:0]   req_pc_q, req_pc_d;
    logic                  req_valid_q, req_valid_d;
    logic                  hold_sel, hold_load;
    logic [PC_WIDTH-1:0]   buf_pc;
    logic [INST_WIDTH-1:0] buf_inst;

    assign hold_sel = (state_q == IFC_HOLD);

    // State and request tracking registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IFC_BOOT;
            fetch_q     <= RST_PC;
            req_valid_q <= 1'b0;
            req_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            fetch_q     <= fetch_d;
            req_valid_q <= req_valid_d;
            req_pc_q    <= req_pc_d;
        end
    end

    // Next state, BRAM issue and output qualification.
    always_comb begin
        state_d     = state_q;
        fetch_d     = fetch_q;
        req_valid_d = req_valid_q;
        req_pc_d    = req_pc_q;
        hold_load   = 1'b0;
        imem_en_o   = 1'b0;
        imem_addr_o = fetch_q;
        if_valid_o  = 1'b0;
        unique case (state_q)
            IFC_BOOT: begin
                imem_en_o   = 1'b1;
                imem_addr_o = RST_PC;
                state_d     = IFC_RUN;
                req_valid_d = 1'b1;
                req_pc_d    = RST_PC;
                fetch_d     = RST_PC + PC_ONE;
            end
            IFC_RUN, IFC_HOLD: begin
                if_valid_o = hold_sel | req_valid_q;
                if (redirect_i) begin
                    // killed instruction is never presented
                    if_valid_o  = 1'b0;
                    imem_en_o   = 1'b1;
                    imem_addr_o = redirect_pc_i;
                    state_d     = IFC_RUN;
                    req_valid_d = 1'b1;
                    req_pc_d    = redirect_pc_i;
                    fetch_d     = redirect_pc_i + PC_ONE;
                end else if (stall_i && if_valid_o) begin
                    hold_load = !hold_sel;
                    state_d   = IFC_HOLD;
                end else begin
                    imem_en_o   = 1'b1;
                    imem_addr_o = fetch_q;
                    state_d     = IFC_RUN;
                    req_valid_d = 1'b1;
                    req_pc_d    = fetch_q;
                    fetch_d     = fetch_q + PC_ONE;
                end
            end
            default: state_d = IFC_BOOT;
        endcase
        if (!rst) begin
            imem_en_o  = 1'b0;
            if_valid_o = 1'b0;
        end
    end

    if_hold_buf #(
        .PC_WIDTH   (PC_WIDTH),
        .INST_WIDTH (INST_WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (hold_load),
        .sel       (hold_sel),
        .live_pc   (req_pc_q),
        .live_inst (imem_rdata_i),
        .pc        (buf_pc),
        .inst      (buf_inst)
    );

    assign if_pc_o   = rst ? buf_pc   : '0;
    assign if_inst_o = rst ? buf_inst : '0;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a 1-cycle BRAM model.
// BRAM holds inst[k] = 0xA000_0000 + k.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [9:0]  redirect_pc_i;
    logic        imem_en_o;
    logic [9:0]  imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [9:0]  if_pc_o;
    logic [31:0] if_inst_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_en_o     (imem_en_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_inst_o     (if_inst_o)
    );

    // Synchronous instruction memory, read data one cycle after enable.
    always @(posedge clk) begin
        if (imem_en_o)
            imem_rdata_i <= 32'hA000_0000 + {22'd0, imem_addr_o};
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        cyc();
        cyc();
        total++;
        if ({if_valid_o, imem_en_o, if_pc_o, if_inst_o} !== 44'd0) begin
            bad++;
            $display("FAIL reset_out got v=%b en=%b pc=%0d inst=%h want all 0",
                     if_valid_o, imem_en_o, if_pc_o, if_inst_o);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({if_valid_o, imem_en_o, imem_addr_o} !== {1'b0, 1'b1, 10'd0}) begin
            bad++;
            $display("FAIL boot got v=%b en=%b addr=%0d want v=0 en=1 addr=0",
                     if_valid_o, imem_en_o, imem_addr_o);
        end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 5; k++) begin
            cyc();
            total++;
            if ({if_valid_o, if_pc_o, if_inst_o, imem_en_o, imem_addr_o} !==
                {1'b1, 10'(k), 32'hA000_0000 + k, 1'b1, 10'(k + 1)}) begin
                bad++;
                $display("FAIL stream%0d got v=%b pc=%0d inst=%h en=%b addr=%0d",
                         k, if_valid_o, if_pc_o, if_inst_o, imem_en_o, imem_addr_o);
            end
        end
    endtask

    task automatic test_stall();
        cyc();
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) stall_i = 1'b0;
            #1;
            total++;
            if ({if_valid_o, if_pc_o, if_inst_o, imem_en_o} !==
                {1'b1, 10'd5, 32'hA000_0005, i == 3}) begin
                bad++;
                $display("FAIL stall_hold%0d got v=%b pc=%0d inst=%h en=%b",
                         i, if_valid_o, if_pc_o, if_inst_o, imem_en_o);
            end
            if (i == 3) begin
                total++;
                if (imem_addr_o !== 10'd6) begin
                    bad++;
                    $display("FAIL stall_release_addr got %0d want 6", imem_addr_o);
                end
            end
            if (i < 3) cyc();
        end
        for (int k = 6; k < 10; k++) begin
            cyc();
            total++;
            if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 10'(k), 32'hA000_0000 + k}) begin
                bad++;
                $display("FAIL after_stall%0d got v=%b pc=%0d inst=%h",
                         k, if_valid_o, if_pc_o, if_inst_o);
            end
        end
    endtask

    task automatic test_redirect();
        redirect_i = 1'b1;
        redirect_pc_i = 10'h040;
        #1;
        total++;
        if ({if_valid_o, imem_en_o, imem_addr_o} !== {1'b0, 1'b1, 10'h040}) begin
            bad++;
            $display("FAIL redir_kill got v=%b en=%b addr=%h want v=0 en=1 addr=040",
                     if_valid_o, imem_en_o, imem_addr_o);
        end
        for (int k = 0; k < 2; k++) begin
            cyc();
            redirect_i = 1'b0;
            #1;
            total++;
            if ({if_valid_o, if_pc_o, if_inst_o} !==
                {1'b1, 10'(64 + k), 32'hA000_0040 + k}) begin
                bad++;
                $display("FAIL redir_tgt%0d got v=%b pc=%h inst=%h",
                         k, if_valid_o, if_pc_o, if_inst_o);
            end
        end
    endtask

    task automatic test_redirect_stall();
        redirect_i = 1'b1;
        redirect_pc_i = 10'd12;
        cyc();
        redirect_i = 1'b0;
        stall_i = 1'b1;
        cyc();
        total++;
        if ({if_valid_o, if_pc_o, if_inst_o, imem_en_o} !==
            {1'b1, 10'd12, 32'hA000_000C, 1'b0}) begin
            bad++;
            $display("FAIL hold12 got v=%b pc=%0d inst=%h en=%b",
                     if_valid_o, if_pc_o, if_inst_o, imem_en_o);
        end
        redirect_i = 1'b1;
        redirect_pc_i = 10'h080;
        #1;
        total++;
        if ({if_valid_o, imem_en_o, imem_addr_o} !== {1'b0, 1'b1, 10'h080}) begin
            bad++;
            $display("FAIL redir_over_stall got v=%b en=%b addr=%h",
                     if_valid_o, imem_en_o, imem_addr_o);
        end
        for (int k = 0; k < 2; k++) begin
            cyc();
            redirect_i = 1'b0;
            stall_i = 1'b0;
            #1;
            total++;
            if ({if_valid_o, if_pc_o, if_inst_o} !==
                {1'b1, 10'(128 + k), 32'hA000_0080 + k}) begin
                bad++;
                $display("FAIL redir_hold_tgt%0d got v=%b pc=%h inst=%h",
                         k, if_valid_o, if_pc_o, if_inst_o);
            end
        end
    endtask

    task automatic test_wrap();
        logic [9:0] exp_pc [4];
        exp_pc[0] = 10'd1022;
        exp_pc[1] = 10'd1023;
        exp_pc[2] = 10'd0;
        exp_pc[3] = 10'd1;
        redirect_i = 1'b1;
        redirect_pc_i = 10'd1022;
        for (int k = 0; k < 4; k++) begin
            cyc();
            redirect_i = 1'b0;
            #1;
            total++;
            if ({if_valid_o, if_pc_o, if_inst_o} !==
                {1'b1, exp_pc[k], 32'hA000_0000 + {22'd0, exp_pc[k]}}) begin
                bad++;
                $display("FAIL wrap%0d got v=%b pc=%0d inst=%h want pc=%0d",
                         k, if_valid_o, if_pc_o, if_inst_o, exp_pc[k]);
            end
        end
    endtask

    task automatic test_reset_hold();
        stall_i = 1'b1;
        cyc();
        total++;
        if ({if_valid_o, if_pc_o, imem_en_o} !== {1'b1, 10'd1, 1'b0}) begin
            bad++;
            $display("FAIL pre_rst_hold got v=%b pc=%0d en=%b",
                     if_valid_o, if_pc_o, imem_en_o);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({if_valid_o, imem_en_o, if_pc_o, if_inst_o} !== 44'd0) begin
            bad++;
            $display("FAIL rst_in_hold got v=%b en=%b pc=%0d inst=%h want all 0",
                     if_valid_o, imem_en_o, if_pc_o, if_inst_o);
        end
        cyc();
        rst = 1'b1;
        stall_i = 1'b0;
        #1;
        total++;
        if ({if_valid_o, imem_en_o, imem_addr_o} !== {1'b0, 1'b1, 10'd0}) begin
            bad++;
            $display("FAIL reboot got v=%b en=%b addr=%0d",
                     if_valid_o, imem_en_o, imem_addr_o);
        end
        for (int k = 0; k < 2; k++) begin
            cyc();
            total++;
            if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 10'(k), 32'hA000_0000 + k}) begin
                bad++;
                $display("FAIL restart%0d got v=%b pc=%0d inst=%h",
                         k, if_valid_o, if_pc_o, if_inst_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_reset_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
